hazard_stall_unit: RTL and testbench

//  Decode-stage stall/flush generator; the stall-side partner of the forwarding unit. Forwarding resolves
//  ALU->ALU hazards; this block detects what forwarding cannot cover and freezes F/D, bubbling E.

---
 rtl/hazard_stall_unit.sv | 89 ++++++++
 tb/tb_hazard_stall_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Decode-stage stall/flush generator for hazards forwarding cannot resolve
// (load-use, D-resolved branch operands, HI/LO access while mult/div busy) plus a stall-cycle counter.
module hazard_stall_unit #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 12,
   parameter int CNT_W   = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [4:0]       i_rsD,
   input  logic [4:0]       i_rtD,
   input  logic             i_useRsD,
   input  logic             i_useRtD,
   input  logic             i_branchD,
   input  logic             i_mdOpD,
   input  logic [4:0]       i_writeRegE,
   input  logic             i_regWriteE,
   input  logic             i_memToRegE,
   input  logic             i_mdStartE,
   input  logic             i_mdIsDivE,
   input  logic [4:0]       i_writeRegM,
   input  logic             i_memToRegM,
   output logic             o_stallF,
   output logic             o_stallD,
   output logic             o_flushE,
   output logic [1:0]       o_stallCause,
   output logic             o_mdBusy,
   output logic [CNT_W-1:0] o_stallCycles
);

   localparam logic [3:0]       MUL_CNT = 4'(MUL_LAT);
   localparam logic [3:0]       DIV_CNT = 4'(DIV_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [3:0]       r_md_cnt;
   logic [CNT_W-1:0] r_stall_cycles;

   logic w_match_e;
   logic w_match_m;
   logic w_load_use;
   logic w_br_haz;
   logic w_md_haz;
   logic w_stall;
   logic [1:0] w_cause;

   assign w_match_e = (i_useRsD && (i_rsD == i_writeRegE)) || (i_useRtD && (i_rtD == i_writeRegE));
   assign w_match_m = (i_useRsD && (i_rsD == i_writeRegM)) || (i_useRtD && (i_rtD == i_writeRegM));

   assign w_load_use = i_memToRegE && i_regWriteE && (i_writeRegE != 5'd0) && w_match_e;
   assign w_br_haz   = i_branchD &&
                       ((i_regWriteE && (i_writeRegE != 5'd0) && w_match_e) ||
                        (i_memToRegM && (i_writeRegM != 5'd0) && w_match_m));
   // An issuing mult/div already counts as busy so a following HI/LO access waits.
   assign w_md_haz   = i_mdOpD && ((r_md_cnt != 4'd0) || i_mdStartE);
   assign w_stall    = !i_reset && (w_load_use || w_br_haz || w_md_haz);

   always_comb begin
      w_cause = 2'd0;
      if (!i_reset) begin
         if (w_load_use)    w_cause = 2'd1;
         else if (w_br_haz) w_cause = 2'd2;
         else if (w_md_haz) w_cause = 2'd3;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_md_cnt       <= 4'd0;
         r_stall_cycles <= '0;
      end else begin
         if (i_mdStartE)
            r_md_cnt <= i_mdIsDivE ? DIV_CNT : MUL_CNT;
         else if (r_md_cnt != 4'd0)
            r_md_cnt <= r_md_cnt - 4'd1;

         if (w_stall && (r_stall_cycles != CNT_MAX))
            r_stall_cycles <= r_stall_cycles + CNT_ONE;
      end
   end

   assign o_stallF      = w_stall;
   assign o_stallD      = w_stall;
   assign o_flushE      = w_stall;
   assign o_stallCause  = w_cause;
   assign o_mdBusy      = !i_reset && (r_md_cnt != 4'd0);
   assign o_stallCycles = i_reset ? '0 : r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit (MUL_LAT=4, DIV_LAT=12, CNT_W=4).
module tb_hazard_stall_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rsD, rtD, writeRegE, writeRegM;
   logic       useRsD, useRtD, branchD, mdOpD;
   logic       regWriteE, memToRegE, mdStartE, mdIsDivE, memToRegM;
   logic       stallF, stallD, flushE, mdBusy;
   logic [1:0] stallCause;
   logic [3:0] stallCycles;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hazard_stall_unit #(.MUL_LAT(4), .DIV_LAT(12), .CNT_W(4)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_rsD(rsD), .i_rtD(rtD), .i_useRsD(useRsD), .i_useRtD(useRtD),
      .i_branchD(branchD), .i_mdOpD(mdOpD),
      .i_writeRegE(writeRegE), .i_regWriteE(regWriteE), .i_memToRegE(memToRegE),
      .i_mdStartE(mdStartE), .i_mdIsDivE(mdIsDivE),
      .i_writeRegM(writeRegM), .i_memToRegM(memToRegM),
      .o_stallF(stallF), .o_stallD(stallD), .o_flushE(flushE),
      .o_stallCause(stallCause), .o_mdBusy(mdBusy), .o_stallCycles(stallCycles)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic idle();
      rsD = 0; rtD = 0; useRsD = 0; useRtD = 0; branchD = 0; mdOpD = 0;
      writeRegE = 0; regWriteE = 0; memToRegE = 0; mdStartE = 0; mdIsDivE = 0;
      writeRegM = 0; memToRegM = 0;
   endtask

   // Advance one edge, then settle inputs away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_use_8();
      memToRegE = 1; regWriteE = 1; writeRegE = 8; useRsD = 1; rsD = 8;
   endtask

   // Checks stall triple, cause and counter after inputs settle.
   task automatic expect_state(input string tag, input logic s, input logic [1:0] c,
                               input logic b, input logic [3:0] cnt);
      #1;
      check_eq({tag, "_stall"}, {29'd0, stallF, stallD, flushE}, {29'd0, s, s, s});
      check_eq({tag, "_cause"}, {30'd0, stallCause}, {30'd0, c});
      check_eq({tag, "_busy"},  {31'd0, mdBusy}, {31'd0, b});
      check_eq({tag, "_cnt"},   {28'd0, stallCycles}, {28'd0, cnt});
   endtask

   initial begin
      idle();
      reset = 1;
      tick();
      // Hazard present while in reset: outputs must stay low.
      load_use_8();
      expect_state("in_reset", 0, 0, 0, 0);
      tick();
      idle();
      reset = 0;
      expect_state("after_reset", 0, 0, 0, 0);

      // Load-use: one stall cycle.
      load_use_8();
      expect_state("load_use", 1, 1, 0, 0);
      tick();
      idle();
      expect_state("load_use_done", 0, 0, 0, 1);

      // Non-hazards.
      load_use_8(); writeRegE = 0; rsD = 0;
      expect_state("reg0", 0, 0, 0, 1);
      idle(); load_use_8(); useRsD = 0;
      expect_state("no_use", 0, 0, 0, 1);
      idle(); regWriteE = 1; writeRegE = 8; useRsD = 1; rsD = 8;
      expect_state("alu_fwd", 0, 0, 0, 1);

      // Branch hazard from ALU in E, then from load in M.
      idle(); branchD = 1; useRtD = 1; rtD = 9; regWriteE = 1; writeRegE = 9;
      expect_state("br_e", 1, 2, 0, 1);
      tick();
      regWriteE = 0; writeRegE = 0; memToRegM = 1; writeRegM = 9;
      expect_state("br_m", 1, 2, 0, 2);
      tick();
      idle();
      expect_state("br_done", 0, 0, 0, 3);

      // Mult issue with mfhi held in D: stalled cycles 0..4.
      mdStartE = 1; mdIsDivE = 0; mdOpD = 1;
      expect_state("mul_c0", 1, 3, 0, 3);
      tick();
      mdStartE = 0;
      for (int i = 1; i <= 4; i++) begin
         expect_state($sformatf("mul_c%0d", i), 1, 3, 1, 4'(3 + i));
         tick();
      end
      expect_state("mul_c5", 0, 0, 0, 8);
      idle();

      // Div issue, reset mid-countdown.
      mdStartE = 1; mdIsDivE = 1;
      tick();
      idle();
      expect_state("div_c1", 0, 0, 1, 8);
      tick(); tick();
      reset = 1;
      expect_state("div_rst", 0, 0, 0, 0);
      tick();
      reset = 0;
      mdOpD = 1;
      expect_state("div_after_rst", 0, 0, 0, 0);
      idle();

      // Load-use plus mult/div hazard: load-use wins.
      load_use_8(); mdStartE = 1; mdOpD = 1;
      expect_state("lu_md", 1, 1, 0, 0);
      tick();
      idle();
      reset = 1;
      tick();
      reset = 0;

      // Saturation: 2^4+3 stall cycles.
      load_use_8();
      for (int i = 0; i < 19; i++) begin
         if (i == 14) expect_state("sat_14", 1, 1, 0, 14);
         tick();
      end
      expect_state("sat_hold", 1, 1, 0, 15);
      idle();
      tick();
      expect_state("sat_end", 0, 0, 0, 15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
